// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter for a byte-wide SDRAM port.
// Port 0 (ioctl download) has fixed priority; ports 1 (CPU) and 2 (ascii
// reader) alternate round-robin. One access is in flight at a time, and an
// optional timeout aborts an access whose memory never signals ready.
//
// state  | meaning
// IDLE   | waiting for a request, arbitrates and latches the winner
// ACCESS | strobe held to memory, waiting for mem_ready or timeout
// DONE   | one-cycle ack to the granted port, requests ignored
module sdram_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock_in,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [47:0] addr,
    input  logic [23:0] wdata,
    output logic [2:0]  ack,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ready
);

    localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TC_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TC = TC_INT[CW-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           rr_pref2;     // 0: port 1 wins a tie, 1: port 2 wins
    logic [CW-1:0]  cnt;
    logic           cur_we;
    logic [1:0]     win;
    logic [15:0]    sel_addr;
    logic [7:0]     sel_wdata;
    logic           sel_we;
    logic           hit_ready;
    logic           hit_timeout;

    // Pick the winning port and mux out its request fields.
    always_comb begin
        win       = 2'd0;
        sel_addr  = addr[15:0];
        sel_wdata = wdata[7:0];
        sel_we    = we[0];
        if (req[0]) begin
            win = 2'd0;
        end else if (req[1] && req[2]) begin
            win = rr_pref2 ? 2'd2 : 2'd1;
        end else if (req[1]) begin
            win = 2'd1;
        end else begin
            win = 2'd2;
        end
        case (win)
            2'd1: begin
                sel_addr  = addr[31:16];
                sel_wdata = wdata[15:8];
                sel_we    = we[1];
            end
            2'd2: begin
                sel_addr  = addr[47:32];
                sel_wdata = wdata[23:16];
                sel_we    = we[2];
            end
            default: ;
        endcase
    end

    // Completion conditions; ready beats timeout in the same cycle.
    always_comb begin
        hit_ready   = (state == ACCESS) && mem_ready;
        hit_timeout = (state == ACCESS) && !mem_ready && (TIMEOUT != 0) && (cnt == TC);
    end

    // State register.
    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != 3'b000) state_nxt = ACCESS;
            ACCESS:  if (hit_ready || hit_timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, latched request and round-robin pointer.
    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            ack      <= 3'b000;
            rdata    <= 8'h00;
            err      <= 1'b0;
            busy     <= 1'b0;
            grant_id <= 2'd0;
            mem_addr <= 16'h0000;
            mem_din  <= 8'h00;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            rr_pref2 <= 1'b0;
            cnt      <= '0;
            cur_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 3'b000) begin
                        grant_id <= win;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_we ? sel_wdata : 8'h00;
                        mem_wr   <= sel_we;
                        mem_rd   <= !sel_we;
                        cur_we   <= sel_we;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        if (win == 2'd1)      rr_pref2 <= 1'b1;
                        else if (win == 2'd2) rr_pref2 <= 1'b0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (hit_ready) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (!cur_we) rdata <= mem_dout;
                        err    <= 1'b0;
                        ack    <= 3'b001 << grant_id;
                    end else if (hit_timeout) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        rdata  <= 8'hFF;
                        err    <= 1'b1;
                        ack    <= 3'b001 << grant_id;
                    end
                end
                DONE: begin
                    ack  <= 3'b000;
                    err  <= 1'b0;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
